// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive NRZI decoder / bit unstuffer.
package usb_rx_pkg;

    // Receiver state: idle bus, inside a packet, or counting an SE0 run.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        SE0  = 2'd2
    } rx_state_t;

    // Line symbol derived from the differential pair {D+, D-}.
    typedef enum logic [1:0] {
        SYM_J   = 2'd0,
        SYM_K   = 2'd1,
        SYM_SE0 = 2'd2,
        SYM_SE1 = 2'd3
    } line_sym_t;

    // D+ level of the idle (J) state on a full-speed bus.
    localparam logic J_LEVEL = 1'b1;

    // Default build parameters.
    localparam int STUFF_LEN_DEF = 6;
    localparam int SE0_MIN_DEF   = 2;
    localparam int SE0_MAX_DEF   = 8;
    localparam int CNT_W_DEF     = 8;

    // Map the sampled pair onto a line symbol.
    function automatic line_sym_t classify_sym(input logic dp, input logic dm);
        line_sym_t s;
        case ({dp, dm})
            2'b10:   s = SYM_J;
            2'b01:   s = SYM_K;
            2'b00:   s = SYM_SE0;
            default: s = SYM_SE1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/usb_bit_unstuffer.sv
// Run-length tracker for decoded 1s. Flags the sample that must be a stuff
// bit and reports a stuff error when that bit decodes as 1.
module usb_bit_unstuffer
    import usb_rx_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_i,     // J/K payload sample taken this cycle
    input  logic bit_i,        // NRZI-decoded value of that sample
    input  logic clear_i,      // packet ended (SE0): forget the run
    output logic stuff_bit_o,  // this sample is a stuff bit, drop it
    output logic stuff_err_o   // stuff bit was a 1
);

    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam logic [OW-1:0] STUFF_LEN_C = OW'(STUFF_LEN);

    logic [OW-1:0] ones_cnt_q;
    logic [OW-1:0] ones_cnt_d;
    logic          stuff_pending;

    // Once the run reaches STUFF_LEN, the very next sample is the stuff bit.
    assign stuff_pending = (ones_cnt_q == STUFF_LEN_C);
    assign stuff_bit_o   = sample_i && stuff_pending;
    assign stuff_err_o   = stuff_bit_o && bit_i;

    // Next run length: a stuff bit or a 0 restarts it, a 1 extends it.
    always_comb begin
        ones_cnt_d = ones_cnt_q;
        if (clear_i) begin
            ones_cnt_d = '0;
        end else if (sample_i) begin
            if (stuff_pending) begin
                ones_cnt_d = '0;
            end else if (bit_i) begin
                ones_cnt_d = ones_cnt_q + 1'b1;
            end else begin
                ones_cnt_d = '0;
            end
        end
    end

    // Run-length register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_cnt_q <= '0;
        end else begin
            ones_cnt_q <= ones_cnt_d;
        end
    end

endmodule

// File: rtl/usb_rx_nrzi_unstuff.sv
// USB receive decoder: classifies line symbols, NRZI-decodes J/K samples,
// removes stuff bits, detects EOP / bus reset and flags line/stuff errors.
// Optional statistics counters are built when DECODE_STATS_EN is defined;
// otherwise stuff_cnt_o / err_cnt_o read as zero and no counter flops exist.
module usb_rx_nrzi_unstuff
    import usb_rx_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEF,
    parameter int SE0_MIN   = SE0_MIN_DEF,
    parameter int SE0_MAX   = SE0_MAX_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_plus_i,
    input  logic             d_minus_i,
    input  logic             shift_enable_i,
    output logic             d_orig_o,
    output logic             bit_valid_o,
    output logic             eop_det_o,
    output logic             stuff_err_o,
    output logic             line_err_o,
    output logic             bus_reset_o,
    output logic [CNT_W-1:0] stuff_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int SW = $clog2(SE0_MAX + 1);
    localparam logic [SW-1:0] SE0_MAX_C = SW'(SE0_MAX);
    localparam logic [SW-1:0] SE0_MIN_C = SW'(SE0_MIN);

    rx_state_t state_q, state_d;
    logic          prev_q, prev_d;
    logic [SW-1:0] se0_cnt_q, se0_cnt_d;
    logic          d_orig_q, d_orig_d;
    logic          bit_valid_q, bit_valid_d;
    logic          eop_q, eop_d;
    logic          stuff_err_q, stuff_err_d;
    logic          line_err_q, line_err_d;
    logic          bus_reset_q, bus_reset_d;

    line_sym_t     sym;
    logic          is_jk;
    logic          dec_bit;
    logic [SW-1:0] se0_inc;
    logic          us_sample;
    logic          us_clear;
    logic          us_stuff_bit;
    logic          us_stuff_err;

    assign sym     = classify_sym(d_plus_i, d_minus_i);
    assign is_jk   = (sym == SYM_J) || (sym == SYM_K);
    // NRZI: no transition means 1, a transition means 0.
    assign dec_bit = (d_plus_i == prev_q);
    // SE0 run length including this sample, saturating at SE0_MAX.
    assign se0_inc = (se0_cnt_q == SE0_MAX_C) ? se0_cnt_q : se0_cnt_q + 1'b1;

    assign us_sample = shift_enable_i && (state_q == DATA) && is_jk;
    assign us_clear  = shift_enable_i && (sym == SYM_SE0);

    usb_bit_unstuffer #(
        .STUFF_LEN (STUFF_LEN)
    ) u_unstuffer (
        .clk         (clk),
        .rst         (rst),
        .sample_i    (us_sample),
        .bit_i       (dec_bit),
        .clear_i     (us_clear),
        .stuff_bit_o (us_stuff_bit),
        .stuff_err_o (us_stuff_err)
    );

    // Next-state and output decode, evaluated only on sample strobes.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        se0_cnt_d   = se0_cnt_q;
        d_orig_d    = d_orig_q;
        bus_reset_d = bus_reset_q;
        bit_valid_d = 1'b0;
        eop_d       = 1'b0;
        stuff_err_d = 1'b0;
        line_err_d  = 1'b0;

        if (shift_enable_i) begin
            if (sym != SYM_SE0) begin
                bus_reset_d = 1'b0;
            end
            if (sym == SYM_SE1) begin
                // Illegal symbol: report, but leave decode context untouched.
                line_err_d = 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (sym == SYM_K) begin
                            // First K after idle J is always a 0 (SYNC start).
                            state_d     = DATA;
                            d_orig_d    = 1'b0;
                            bit_valid_d = 1'b1;
                            prev_d      = 1'b0;
                        end else if (sym == SYM_SE0) begin
                            state_d     = SE0;
                            se0_cnt_d   = se0_inc;
                            bus_reset_d = (se0_inc == SE0_MAX_C);
                        end else begin
                            prev_d = J_LEVEL;
                        end
                    end
                    DATA: begin
                        if (sym == SYM_SE0) begin
                            // SE0 beats any pending stuff bit; the unstuffer clears itself.
                            state_d     = SE0;
                            se0_cnt_d   = se0_inc;
                            bus_reset_d = (se0_inc == SE0_MAX_C);
                        end else begin
                            prev_d = d_plus_i;
                            if (us_stuff_bit) begin
                                if (us_stuff_err) begin
                                    stuff_err_d = 1'b1;
                                    state_d     = IDLE;
                                end
                            end else begin
                                d_orig_d    = dec_bit;
                                bit_valid_d = 1'b1;
                            end
                        end
                    end
                    SE0: begin
                        if (sym == SYM_SE0) begin
                            se0_cnt_d   = se0_inc;
                            bus_reset_d = (se0_inc == SE0_MAX_C);
                        end else begin
                            // J closes the run as an EOP if long enough; K never does.
                            if ((sym == SYM_J) && (se0_cnt_q >= SE0_MIN_C)) begin
                                eop_d = 1'b1;
                            end else begin
                                line_err_d = 1'b1;
                            end
                            state_d   = IDLE;
                            prev_d    = J_LEVEL;
                            se0_cnt_d = '0;
                        end
                    end
                    default: begin
                        state_d   = IDLE;
                        prev_d    = J_LEVEL;
                        se0_cnt_d = '0;
                    end
                endcase
            end
        end
    end

    // Decoder state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prev_q      <= J_LEVEL;
            se0_cnt_q   <= '0;
            d_orig_q    <= 1'b1;
            bit_valid_q <= 1'b0;
            eop_q       <= 1'b0;
            stuff_err_q <= 1'b0;
            line_err_q  <= 1'b0;
            bus_reset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            se0_cnt_q   <= se0_cnt_d;
            d_orig_q    <= d_orig_d;
            bit_valid_q <= bit_valid_d;
            eop_q       <= eop_d;
            stuff_err_q <= stuff_err_d;
            line_err_q  <= line_err_d;
            bus_reset_q <= bus_reset_d;
        end
    end

    assign d_orig_o    = d_orig_q;
    assign bit_valid_o = bit_valid_q;
    assign eop_det_o   = eop_q;
    assign stuff_err_o = stuff_err_q;
    assign line_err_o  = line_err_q;
    assign bus_reset_o = bus_reset_q;

`ifdef DECODE_STATS_EN
    logic [CNT_W-1:0] stuff_cnt_q, stuff_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             stuff_rm;

    // A stuff bit was dropped cleanly (decoded 0).
    assign stuff_rm = us_stuff_bit && !us_stuff_err;

    // Saturating event counters, updated on the same edge as the pulses.
    always_comb begin
        stuff_cnt_d = stuff_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (stuff_rm && (stuff_cnt_q != {CNT_W{1'b1}})) begin
            stuff_cnt_d = stuff_cnt_q + 1'b1;
        end
        if ((stuff_err_d || line_err_d) && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stuff_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            stuff_cnt_q <= stuff_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign stuff_cnt_o = stuff_cnt_q;
    assign err_cnt_o   = err_cnt_q;
`else
    assign stuff_cnt_o = '0;
    assign err_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_usb_rx_nrzi_unstuff.sv
// Directed bench for usb_rx_nrzi_unstuff: symbol sequences with hand-derived
// expected pulses, decoded bits, bus_reset level and statistics counters.
module tb_usb_rx_nrzi_unstuff;

    localparam int CNT_W = 8;
`ifdef DECODE_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             d_plus = 1'b1;
    logic             d_minus = 1'b0;
    logic             shift_enable = 1'b0;
    logic             d_orig;
    logic             bit_valid;
    logic             eop_det;
    logic             stuff_err;
    logic             line_err;
    logic             bus_reset;
    logic [CNT_W-1:0] stuff_cnt;
    logic [CNT_W-1:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    usb_rx_nrzi_unstuff #(
        .STUFF_LEN (6),
        .SE0_MIN   (2),
        .SE0_MAX   (8),
        .CNT_W     (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .d_plus_i       (d_plus),
        .d_minus_i      (d_minus),
        .shift_enable_i (shift_enable),
        .d_orig_o       (d_orig),
        .bit_valid_o    (bit_valid),
        .eop_det_o      (eop_det),
        .stuff_err_o    (stuff_err),
        .line_err_o     (line_err),
        .bus_reset_o    (bus_reset),
        .stuff_cnt_o    (stuff_cnt),
        .err_cnt_o      (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one symbol for a single sample strobe; outputs settle #1 after the edge.
    task automatic sym(input logic dp, input logic dm);
        @(negedge clk);
        d_plus       = dp;
        d_minus      = dm;
        shift_enable = 1'b1;
        @(posedge clk);
        #1;
        shift_enable = 1'b0;
    endtask

    // Pulses packed as {bit_valid, eop_det, stuff_err, line_err}.
    task automatic expect_out(input string tag, input logic [3:0] p, input logic d, input logic br);
        chk({tag, "_pulses"}, 32'({bit_valid, eop_det, stuff_err, line_err}), 32'(p));
        chk({tag, "_d_orig"}, 32'(d_orig), 32'(d));
        chk({tag, "_bus_reset"}, 32'(bus_reset), 32'(br));
        $display("step %-12s pulses=%b d_orig=%b bus_reset=%b", tag,
                 {bit_valid, eop_det, stuff_err, line_err}, d_orig, bus_reset);
    endtask

    task automatic j_s();   sym(1'b1, 1'b0); endtask
    task automatic k_s();   sym(1'b0, 1'b1); endtask
    task automatic se0_s(); sym(1'b0, 1'b0); endtask
    task automatic se1_s(); sym(1'b1, 1'b1); endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 4'b0000, 1'b1, 1'b0);
        chk("reset_stuff_cnt", 32'(stuff_cnt), 32'd0);
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: idle J samples produce nothing
        for (int i = 0; i < 3; i++) begin
            j_s();
            expect_out("idle_j", 4'b0000, 1'b1, 1'b0);
        end

        // 2: K,K,J,K -> 0,1,0,0
        k_s(); expect_out("kkjk_0", 4'b1000, 1'b0, 1'b0);
        k_s(); expect_out("kkjk_1", 4'b1000, 1'b1, 1'b0);
        j_s(); expect_out("kkjk_2", 4'b1000, 1'b0, 1'b0);
        k_s(); expect_out("kkjk_3", 4'b1000, 1'b0, 1'b0);

        // 5: EOP, then next K decodes 0
        se0_s(); expect_out("eop_se0a", 4'b0000, 1'b0, 1'b0);
        se0_s(); expect_out("eop_se0b", 4'b0000, 1'b0, 1'b0);
        j_s();   expect_out("eop_j", 4'b0100, 1'b0, 1'b0);
        // pulses drop on a cycle without strobe
        @(negedge clk); @(posedge clk); #1;
        expect_out("gap", 4'b0000, 1'b0, 1'b0);
        k_s();   expect_out("post_eop_k", 4'b1000, 1'b0, 1'b0);

        // 3: six 1s, then J stuff bit (decodes 0) is dropped
        for (int i = 0; i < 6; i++) begin
            k_s(); expect_out("ones", 4'b1000, 1'b1, 1'b0);
        end
        j_s(); expect_out("stuff_j", 4'b0000, 1'b1, 1'b0);
        chk("stuff_cnt_1", 32'(stuff_cnt), 32'(STATS));
        k_s(); expect_out("after_stuff", 4'b1000, 1'b0, 1'b0);
        se0_s(); se0_s();
        j_s(); expect_out("eop2", 4'b0100, 1'b0, 1'b0);

        // 4: six 1s then no transition -> stuff error, back to IDLE
        k_s(); expect_out("p4_k", 4'b1000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            k_s(); expect_out("p4_ones", 4'b1000, 1'b1, 1'b0);
        end
        k_s(); expect_out("stuff_err", 4'b0010, 1'b1, 1'b0);
        chk("err_cnt_1", 32'(err_cnt), 32'(STATS));
        chk("stuff_cnt_keep", 32'(stuff_cnt), 32'(STATS));
        j_s(); expect_out("idle_after_err", 4'b0000, 1'b1, 1'b0);
        k_s(); expect_out("restart_k", 4'b1000, 1'b0, 1'b0);
        // short SE0 run ended by J
        se0_s();
        j_s(); expect_out("short_se0", 4'b0001, 1'b0, 1'b0);
        chk("err_cnt_2", 32'(err_cnt), 32'(2 * STATS));

        // 6: SE0 x8 -> bus_reset, J -> EOP and clear
        for (int i = 1; i <= 8; i++) begin
            se0_s();
            expect_out("se0_run", 4'b0000, 1'b0, (i == 8) ? 1'b1 : 1'b0);
        end
        j_s(); expect_out("bus_reset_j", 4'b0100, 1'b0, 1'b0);
        se0_s();
        j_s(); expect_out("se0_1_j", 4'b0001, 1'b0, 1'b0);
        chk("err_cnt_3", 32'(err_cnt), 32'(3 * STATS));

        // SE0 run ended by K is an error
        se0_s(); se0_s();
        k_s(); expect_out("se0_k", 4'b0001, 1'b0, 1'b0);

        // SE1 mid-packet: error, prev_level unchanged
        k_s();   expect_out("se1_pre", 4'b1000, 1'b0, 1'b0);
        se1_s(); expect_out("se1", 4'b0001, 1'b0, 1'b0);
        k_s();   expect_out("se1_post", 4'b1000, 1'b1, 1'b0);
        chk("err_cnt_5", 32'(err_cnt), 32'(5 * STATS));

        // Reset mid-packet returns to IDLE / J
        @(negedge clk);
        rst = 1'b1;
        #1;
        expect_out("mid_reset", 4'b0000, 1'b1, 1'b0);
        chk("mid_reset_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        k_s(); expect_out("reset_k", 4'b1000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
